// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Patterns are active-low, ordered {dp, g, f, e, d, c, b, a}; dp is off in every constant.
package seg7_pkg;

  localparam logic [7:0] SEG7_BLANK = 8'hFF;
  localparam logic [7:0] DIG0 = 8'hC0;
  localparam logic [7:0] DIG1 = 8'hF9;
  localparam logic [7:0] DIG2 = 8'hA4;
  localparam logic [7:0] DIG3 = 8'hB0;
  localparam logic [7:0] DIG4 = 8'h99;
  localparam logic [7:0] DIG5 = 8'h92;
  localparam logic [7:0] DIG6 = 8'h82;
  localparam logic [7:0] DIG7 = 8'hF8;
  localparam logic [7:0] DIG8 = 8'h80;
  localparam logic [7:0] DIG9 = 8'h90;

  typedef enum logic {BLANK, SHOW} slot_e;

  function automatic logic [7:0] seg7_with_dp(logic [6:0] pattern, logic dp_on);
    return {~dp_on, pattern};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Datapath/display-side signal bundle of the 7-segment scan controller.
// The master side drives load/value/dp_mask; the controller (slave) drives the display pins.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic                      ack;
  logic                      frame_start;
  logic [NUM_DIGITS-1:0]     anode;
  logic [7:0]                seg;

  modport master (
    output load, value, dp_mask,
    input  ack, frame_start, anode, seg
  );

  modport slave (
    input  load, value, dp_mask,
    output ack, frame_start, anode, seg
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder ({g..a}); codes 10-15 decode to blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG7_BLANK[6:0];
    case (bcd_i)
      4'd0:    seg_o = DIG0[6:0];
      4'd1:    seg_o = DIG1[6:0];
      4'd2:    seg_o = DIG2[6:0];
      4'd3:    seg_o = DIG3[6:0];
      4'd4:    seg_o = DIG4[6:0];
      4'd5:    seg_o = DIG5[6:0];
      4'd6:    seg_o = DIG6[6:0];
      4'd7:    seg_o = DIG7[6:0];
      4'd8:    seg_o = DIG8[6:0];
      4'd9:    seg_o = DIG9[6:0];
      default: seg_o = SEG7_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with frame-aligned double buffering.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter int GUARD      = 2
) (
  input logic             clk,
  input logic             rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int P_W = $clog2(CLK_DIV);
  localparam int I_W = $clog2(NUM_DIGITS);
  localparam logic [P_W-1:0] P_LAST  = P_W'(CLK_DIV - 1);
  localparam logic [P_W-1:0] P_GUARD = P_W'(GUARD);
  localparam logic [I_W-1:0] I_LAST  = I_W'(NUM_DIGITS - 1);

  logic [P_W-1:0]            p_q, p_d;
  logic [I_W-1:0]            idx_q, idx_d;
  logic                      run_q;
  logic [4*NUM_DIGITS-1:0]   disp_q, pend_q;
  logic [NUM_DIGITS-1:0]     dp_disp_q, dp_pend_q;
  logic                      pend_v_q;

  logic [NUM_DIGITS-1:0]     anode_q, anode_d;
  logic [7:0]                seg_q, seg_d;
  logic                      ack_q, fs_q, fs_d;

  logic                      commit;
  slot_e                     slot_d;
  logic [3:0]                nib;
  logic [6:0]                dec_seg;
  logic [NUM_DIGITS-1:0]     lz_blank;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it hold 0.
  assign lz_blank[0] = 1'b0;
  genvar gi;
  for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lz_blank[gi] = ~|disp_q[4*NUM_DIGITS-1:4*gi];
  end
`else
  assign lz_blank = '0;
`endif

  seg7_decode u_decode (
    .bcd_i (nib),
    .seg_o (dec_seg)
  );

  // Outputs are computed from the next (idx, p) and registered, so they line up with
  // the counter registers. run_q holds the counter at (0,0) for the first edge after
  // reset so that the first frame_start lands on the first post-reset cycle.
  always_comb begin
    p_d     = p_q;
    idx_d   = idx_q;
    commit  = run_q && (p_q == P_LAST) && (idx_q == I_LAST) && pend_v_q;
    if (run_q) begin
      if (p_q == P_LAST) begin
        p_d   = '0;
        idx_d = (idx_q == I_LAST) ? '0 : idx_q + I_W'(1);
      end else begin
        p_d = p_q + P_W'(1);
      end
    end

    slot_d  = (p_d < P_GUARD) ? BLANK : SHOW;
    nib     = disp_q[{idx_d, 2'b00} +: 4];
    anode_d = '1;
    seg_d   = SEG7_BLANK;
    if (slot_d == SHOW) begin
      anode_d[idx_d] = 1'b0;
      seg_d = seg7_with_dp(lz_blank[idx_d] ? SEG7_BLANK[6:0] : dec_seg, dp_disp_q[idx_d]);
    end
    fs_d = (p_d == '0) && (idx_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      idx_q     <= '0;
      run_q     <= 1'b0;
      disp_q    <= {NUM_DIGITS{4'hF}};
      dp_disp_q <= '0;
      pend_q    <= '0;
      dp_pend_q <= '0;
      pend_v_q  <= 1'b0;
      anode_q   <= '1;
      seg_q     <= SEG7_BLANK;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
      run_q <= 1'b1;
      if (commit) begin
        disp_q    <= pend_q;
        dp_disp_q <= dp_pend_q;
      end
      // A load coinciding with a commit lands behind the value being committed.
      if (bus.load) begin
        pend_q    <= bus.value;
        dp_pend_q <= bus.dp_mask;
      end
      pend_v_q <= bus.load | (pend_v_q & ~commit);
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      ack_q    <= commit;
      fs_q     <= fs_d;
    end
  end

  assign bus.anode       = anode_q;
  assign bus.seg         = seg_q;
  assign bus.ack         = ack_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus randomized loads
// compared every cycle against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = ND * CD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GUARD(GD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: k counts cycles since reset release (-1 = held in reset state).
  int          m_k       = -1;
  logic [15:0] m_disp    = 16'hFFFF;
  logic [15:0] m_pend    = 16'h0;
  logic [3:0]  m_dp      = 4'h0;
  logic [3:0]  m_dp_pend = 4'h0;
  logic        m_pend_v  = 1'b0;
  logic        m_ack     = 1'b0;

  function automatic bit is_boundary(int k);
    return (k >= 0) && ((k % FRAME) == FRAME - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k      <= -1;
      m_disp   <= 16'hFFFF;
      m_dp     <= 4'h0;
      m_pend_v <= 1'b0;
      m_ack    <= 1'b0;
    end else begin
      m_k   <= m_k + 1;
      m_ack <= m_pend_v && is_boundary(m_k);
      if (m_pend_v && is_boundary(m_k)) begin
        m_disp <= m_pend;
        m_dp   <= m_dp_pend;
      end
      if (bus.load) begin
        m_pend    <= bus.value;
        m_dp_pend <= bus.dp_mask;
      end
      m_pend_v <= bus.load || (m_pend_v && !is_boundary(m_k));
    end
  end

  function automatic logic [7:0] pat(logic [3:0] n);
    case (n)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] exp_anode(int k);
    logic [3:0] a;
    a = 4'hF;
    if (k >= 0 && (k % CD) >= GD) a[(k / CD) % ND] = 1'b0;
    return a;
  endfunction

  function automatic logic [7:0] exp_seg(int k);
    int d;
    logic [7:0] s;
    if (k < 0 || (k % CD) < GD) return 8'hFF;
    d = (k / CD) % ND;
    s = pat(m_disp[4*d +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      bit upper_zero;
      upper_zero = 1'b1;
      for (int j = d; j < ND; j++) if (m_disp[4*j +: 4] != 4'd0) upper_zero = 1'b0;
      if (d > 0 && upper_zero) s = 8'hFF;
    end
`endif
    s[7] = ~m_dp[d];
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    tick();
    rst      = 1'b1;
    bus.load = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int max, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < max) begin
      tick();
      cycles++;
      if (bus.ack === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_fs(input int max, output bit seen);
    int c;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < max) begin
      tick();
      c++;
      if (bus.frame_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if ({bus.anode, bus.seg, bus.ack, bus.frame_start} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: anode=%h seg=%h ack=%b fs=%b, want anode=f seg=ff ack=0 fs=0",
               bus.anode, bus.seg, bus.ack, bus.frame_start);
    end
    tick();
    n_checks++;
    if ({bus.anode, bus.seg, bus.ack, bus.frame_start} !== {4'hF, 8'hFF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_cycle: anode=%h seg=%h ack=%b fs=%b, want f ff 0 1",
               bus.anode, bus.seg, bus.ack, bus.frame_start);
    end
    tick();
    n_checks++;
    if ({bus.anode, bus.seg, bus.frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_guard_cycle: anode=%h seg=%h fs=%b, want f ff 0",
               bus.anode, bus.seg, bus.frame_start);
    end
    tick();
    n_checks++;
    if ({bus.anode, bus.seg} !== {4'b1110, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_first_show: anode=%b seg=%h, want 1110 ff", bus.anode, bus.seg);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_display();
    bit seen;
    int cyc, extra;
    logic [7:0] want [4];
    logic [3:0] an_w;
    want[0] = 8'h99; want[1] = 8'hB0; want[2] = 8'h24; want[3] = 8'hF9;
    bus.load = 1'b1; bus.value = 16'h1234; bus.dp_mask = 4'b0100;
    tick();
    bus.load = 1'b0;
    wait_ack(2 * FRAME + 2, seen, cyc);
    n_checks++;
    if ({seen, bus.frame_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL load_ack: ack_seen=%b fs=%b after %0d cycles, want ack with fs", seen, bus.frame_start, cyc);
    end
    extra = 0;
    for (int c = 1; c < FRAME; c++) begin
      tick();
      if (bus.ack === 1'b1) extra++;
      if (c % CD == GD) begin
        an_w = 4'hF;
        an_w[c / CD] = 1'b0;
        n_checks++;
        if ({bus.anode, bus.seg} !== {an_w, want[c / CD]}) begin
          n_fail++;
          $display("FAIL load_digit%0d: anode=%b seg=%h, want %b %h", c / CD, bus.anode, bus.seg, an_w, want[c / CD]);
        end
      end
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL load_single_ack: extra acks=%0d, want 0", extra);
    end
    $display("test_load_display done");
  endtask

  task automatic test_two_loads();
    bit seen;
    int cyc, extra;
    wait_fs(FRAME + 1, seen);
    bus.load = 1'b1; bus.value = 16'h1111; bus.dp_mask = 4'h0;
    tick();
    bus.value = 16'h2222;
    tick();
    bus.load = 1'b0;
    wait_ack(2 * FRAME, seen, cyc);
    n_checks++;
    if ({seen, cyc} !== {1'b1, 32'(FRAME - 2)}) begin
      n_fail++;
      $display("FAIL two_loads_ack: seen=%b cycles=%0d, want 1 %0d", seen, cyc, FRAME - 2);
    end
    extra = 0;
    for (int c = 1; c < FRAME; c++) begin
      tick();
      if (bus.ack === 1'b1) extra++;
      if (c % CD == GD) begin
        n_checks++;
        if (bus.seg !== 8'hA4) begin
          n_fail++;
          $display("FAIL two_loads_digit%0d: seg=%h, want a4", c / CD, bus.seg);
        end
      end
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL two_loads_one_ack: extra acks=%0d, want 0", extra);
    end
    $display("test_two_loads done");
  endtask

  task automatic test_load_on_commit();
    bit seen;
    int cyc;
    wait_fs(FRAME + 1, seen);
    bus.load = 1'b1; bus.value = 16'h5678; bus.dp_mask = 4'h0;
    tick();
    bus.load = 1'b0;
    repeat (FRAME - 2) tick();
    bus.load = 1'b1; bus.value = 16'h9012; bus.dp_mask = 4'b0001;
    tick();
    bus.load = 1'b0;
    n_checks++;
    if ({bus.ack, bus.frame_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL commit_cycle_ack: ack=%b fs=%b, want 1 1", bus.ack, bus.frame_start);
    end
    repeat (GD) tick();
    n_checks++;
    if ({bus.anode, bus.seg} !== {4'b1110, 8'h80}) begin
      n_fail++;
      $display("FAIL commit_old_value: anode=%b seg=%h, want 1110 80", bus.anode, bus.seg);
    end
    wait_ack(FRAME + 1, seen, cyc);
    n_checks++;
    if ({seen, cyc} !== {1'b1, 32'(FRAME - GD)}) begin
      n_fail++;
      $display("FAIL commit_second_ack: seen=%b cycles=%0d, want 1 %0d", seen, cyc, FRAME - GD);
    end
    repeat (GD) tick();
    n_checks++;
    if (bus.seg !== 8'h24) begin
      n_fail++;
      $display("FAIL commit_new_value: seg=%h, want 24", bus.seg);
    end
    $display("test_load_on_commit done");
  endtask

  task automatic test_zero_blank();
    bit seen;
    int cyc;
    logic [7:0] want [4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    want[0] = 8'hC0; want[1] = 8'hFF; want[2] = 8'hFF; want[3] = 8'hFF;
`else
    want[0] = 8'hC0; want[1] = 8'hFF; want[2] = 8'hC0; want[3] = 8'hC0;
`endif
    bus.load = 1'b1; bus.value = 16'h00A0; bus.dp_mask = 4'h0;
    tick();
    bus.load = 1'b0;
    wait_ack(2 * FRAME + 2, seen, cyc);
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_ack: no ack within %0d cycles", cyc);
    end
    for (int c = 1; c < FRAME; c++) begin
      tick();
      if (c % CD == GD) begin
        n_checks++;
        if (bus.seg !== want[c / CD]) begin
          n_fail++;
          $display("FAIL zero_digit%0d: seg=%h, want %h", c / CD, bus.seg, want[c / CD]);
        end
      end
    end
    $display("test_zero_blank done");
  endtask

  task automatic test_reset_mid();
    bit seen;
    int acks, lit;
    wait_fs(FRAME + 1, seen);
    bus.load = 1'b1; bus.value = 16'h4321; bus.dp_mask = 4'hF;
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.anode, bus.ack, bus.frame_start} !== {4'hF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_state: anode=%h ack=%b fs=%b, want f 0 0", bus.anode, bus.ack, bus.frame_start);
    end
    acks = 0;
    lit  = 0;
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      tick();
      if (bus.ack === 1'b1) acks++;
      if (bus.seg !== 8'hFF) lit++;
    end
    n_checks++;
    if ({acks, lit} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL midreset_discard: acks=%0d lit_cycles=%0d, want 0 0", acks, lit);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [15:0] mask;
    do_reset(2);
    for (int i = 0; i < 8 * FRAME; i++) begin
      n_checks++;
      if ({bus.anode, bus.seg, bus.ack, bus.frame_start} !==
          {exp_anode(m_k), exp_seg(m_k), m_ack, (m_k >= 0 && (m_k % FRAME) == 0)}) begin
        n_fail++;
        $display("FAIL random_k%0d: anode=%h seg=%h ack=%b fs=%b, want anode=%h seg=%h ack=%b fs=%b",
                 m_k, bus.anode, bus.seg, bus.ack, bus.frame_start,
                 exp_anode(m_k), exp_seg(m_k), m_ack, (m_k >= 0 && (m_k % FRAME) == 0));
      end
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      bus.load    = ($urandom_range(0, 11) == 0);
      bus.value   = 16'($urandom) & mask;
      bus.dp_mask = 4'($urandom);
      tick();
    end
    bus.load = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.value   = '0;
    bus.dp_mask = '0;
    test_reset();
    test_load_display();
    test_two_loads();
    test_load_on_commit();
    test_zero_blank();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
